stopwatch_lap_cu: RTL
=====================

Name: stopwatch_lap_cu

Overview:
Control unit that sequences the stopwatch datapath, replacing the basic run/stop/clear controller with one that adds a lap (split) function. It takes debounced one-cycle button pulses, drives run/stop, clear and mode to the datapath, and captures a lap snapshot of the msec/sec counts. It also selects whether the FND controller shows the live counts or the frozen lap value for a fixed hold time.

Parameters:
MSEC_MAX, 100, msec count modulus; msec width = $clog2(MSEC_MAX)
SEC_MAX, 60, sec count modulus; sec width = $clog2(SEC_MAX)
HOLD_TICKS, 300, lap display hold length in i_tick pulses (300 x 10 ms = 3 s)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_runstop  input  1  debounced run/stop pulse, one cycle wide
i_clear  input  1  debounced clear pulse, one cycle wide
i_lap  input  1  debounced lap pulse, one cycle wide
i_mode_sw  input  1  mode switch level (sw0)
i_tick  input  1  10 ms tick pulse from the datapath, one cycle wide
i_msec  input  $clog2(MSEC_MAX)  live msec count from the datapath
i_sec  input  $clog2(SEC_MAX)  live sec count from the datapath
o_runstop  output  1  datapath run enable (level)
o_clear  output  1  datapath clear, one-cycle pulse
o_mode  output  1  latched mode to the datapath
o_lap_active  output  1  high while the lap value is displayed (LED)
o_disp_msec  output  $clog2(MSEC_MAX)  msec value to the FND controller
o_disp_sec  output  $clog2(SEC_MAX)  sec value to the FND controller

Behaviour:
- All registers update on posedge clk. With reset=1 at an edge: state=IDLE, o_runstop=0, o_clear=0, o_mode=0, lap registers=0, hold counter=0, o_lap_active=0. Reset asserted mid-hold or mid-run aborts immediately to IDLE.
- FSM states: IDLE, RUN, STOP, LAP. Input priority in the same cycle: i_runstop > i_clear > i_lap. Lower-priority inputs are discarded.
- IDLE: i_runstop -> RUN. i_clear -> IDLE with an o_clear pulse. i_lap is ignored.
- RUN: i_runstop -> STOP. i_lap -> LAP; lap_msec/lap_sec <= i_msec/i_sec in that cycle; hold counter <= 0. i_clear is ignored.
- LAP: i_runstop -> STOP, display returns to live. i_lap recaptures the current counts and resets the hold counter to 0 (stays in LAP). i_clear is ignored. On each i_tick the hold counter increments. An i_tick arriving while the counter = HOLD_TICKS-1 -> RUN.
- STOP: i_runstop -> RUN. i_clear -> IDLE with an o_clear pulse. i_lap is ignored.
- Output decode is registered, so outputs change in the cycle after the triggering input.
  - o_runstop = 1 in RUN and LAP.
  - o_lap_active = 1 in LAP.
  - o_clear is a pulse exactly 1 cycle wide, asserted in the cycle after the accepted i_clear.
- Mode: o_mode <= i_mode_sw every cycle while the state is IDLE or STOP. In RUN and LAP, o_mode holds its value and switch changes take effect only after stopping.
- Display mux is combinational. o_disp_* = o_lap_active ? lap registers : i_msec/i_sec.
- The datapath keeps counting during LAP. Only the display is frozen.
- Hold counter width is $clog2(HOLD_TICKS+1). It never wraps, because exit occurs at HOLD_TICKS-1.
- An i_tick coincident with i_lap in LAP: the recapture wins and the counter = 0.
- An i_tick coincident with i_runstop in LAP: the state goes to STOP.

Test Plan:
1. Assert reset 2 cycles, then release -> state IDLE; all outputs 0; o_disp_* follows i_msec/i_sec.
2. Pulse i_runstop in IDLE -> o_runstop=1 one cycle later. Pulse it again -> o_runstop=0 (STOP). Pulse i_clear -> o_clear high for exactly 1 cycle, state IDLE.
3. In RUN with i_sec=12 and i_msec=45, pulse i_lap -> o_lap_active=1 and o_disp shows 12.45 while the live inputs advance. After the 300th i_tick, o_lap_active=0 and o_disp is live, state RUN.
4. In LAP after 150 ticks, pulse i_lap at 14.02 -> display shows 14.02 and a full 300 further ticks are needed before release.
5. Pulse i_clear in RUN -> no o_clear pulse, o_runstop stays 1. Pulse i_runstop and i_lap in the same cycle in RUN -> STOP, no capture, o_lap_active stays 0.
6. Toggle i_mode_sw 0->1 in RUN -> o_mode stays 0. Pulse i_runstop (STOP) -> o_mode=1 within 1 cycle. Assert reset during LAP -> IDLE and all outputs 0 the next cycle.

Source files
------------

// File: rtl/stopwatch_lap_cu.sv
// Stopwatch control unit: run/stop/clear sequencing plus a lap (split) display
// that freezes a snapshot of the msec/sec counts for HOLD_TICKS ticks.
module stopwatch_lap_cu #(
    parameter int unsigned MSEC_MAX   = 100,
    parameter int unsigned SEC_MAX    = 60,
    parameter int unsigned HOLD_TICKS = 300
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_runstop,
    input  logic                        i_clear,
    input  logic                        i_lap,
    input  logic                        i_mode_sw,
    input  logic                        i_tick,
    input  logic [$clog2(MSEC_MAX)-1:0] i_msec,
    input  logic [$clog2(SEC_MAX)-1:0]  i_sec,
    output logic                        o_runstop,
    output logic                        o_clear,
    output logic                        o_mode,
    output logic                        o_lap_active,
    output logic [$clog2(MSEC_MAX)-1:0] o_disp_msec,
    output logic [$clog2(SEC_MAX)-1:0]  o_disp_sec
);
    localparam int unsigned MW = $clog2(MSEC_MAX);
    localparam int unsigned SW = $clog2(SEC_MAX);
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

    state_t          state_q, state_d;
    logic            runstop_q, clear_q, clear_d, mode_q, lap_active_q;
    logic [MW-1:0]   lap_msec_q, lap_msec_d;
    logic [SW-1:0]   lap_sec_q, lap_sec_d;
    logic [HW-1:0]   hold_q, hold_d;

    always_comb begin
        state_d    = state_q;
        clear_d    = 1'b0;
        lap_msec_d = lap_msec_q;
        lap_sec_d  = lap_sec_q;
        hold_d     = hold_q;
        case (state_q)
            IDLE, STOP: begin
                if (i_runstop) begin
                    state_d = RUN;
                end else if (i_clear) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
            end
            RUN: begin
                if (i_runstop) begin
                    state_d = STOP;
                end else if (i_lap) begin
                    state_d    = LAP;
                    lap_msec_d = i_msec;
                    lap_sec_d  = i_sec;
                    hold_d     = '0;
                end
            end
            LAP: begin
                // Recapture outranks a coincident tick; release on the tick
                // that would make the count reach HOLD_TICKS.
                if (i_runstop) begin
                    state_d = STOP;
                    hold_d  = '0;
                end else if (i_lap) begin
                    lap_msec_d = i_msec;
                    lap_sec_d  = i_sec;
                    hold_d     = '0;
                end else if (i_tick) begin
                    if (hold_q == HW'(HOLD_TICKS - 1)) begin
                        state_d = RUN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            runstop_q    <= 1'b0;
            clear_q      <= 1'b0;
            mode_q       <= 1'b0;
            lap_active_q <= 1'b0;
            lap_msec_q   <= '0;
            lap_sec_q    <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            runstop_q    <= (state_d == RUN) || (state_d == LAP);
            clear_q      <= clear_d;
            lap_active_q <= (state_d == LAP);
            lap_msec_q   <= lap_msec_d;
            lap_sec_q    <= lap_sec_d;
            hold_q       <= hold_d;
            if ((state_q == IDLE) || (state_q == STOP)) begin
                mode_q <= i_mode_sw;
            end
        end
    end

    assign o_runstop    = runstop_q;
    assign o_clear      = clear_q;
    assign o_mode       = mode_q;
    assign o_lap_active = lap_active_q;
    assign o_disp_msec  = lap_active_q ? lap_msec_q : i_msec;
    assign o_disp_sec   = lap_active_q ? lap_sec_q  : i_sec;

endmodule
